// File: rtl/bcd_up_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_up_counter_pkg
// Description : Shared constants and the BCD nibble validity test used by the
//               cascaded BCD up-counter and its per-digit sub-module.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_up_counter_pkg;

   localparam int         DIGIT_W = 4;
   localparam logic [3:0] BCD_MAX = 4'd9;

   // A nibble is valid BCD when it encodes a decimal digit 0..9.
   function automatic logic is_bcd(input logic [DIGIT_W-1:0] nibble);
      return (nibble <= BCD_MAX);
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_up_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_up_digit
// Description : One decade of a cascaded BCD up-counter. Counts 0..9 and
//               raises CEO while enabled at 9 so the next decade advances.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_up_digit
   import bcd_up_counter_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               CE,
   input  logic [DIGIT_W-1:0] data,
   output logic [DIGIT_W-1:0] count,
   output logic               CEO
);

   // Carry to the next decade: enabled while this digit is about to roll over.
   assign CEO = CE && (count == BCD_MAX);

   // Digit register: reset, then parallel load, then increment with 9 -> 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= data;
      end else if (CE) begin
         if (count == BCD_MAX) begin
            count <= '0;
         end else begin
            count <= count + 4'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/bcd_up_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_up_counter
// Description : Cascaded multi-digit BCD up-counter with parallel load, load
//               validation (error), sticky overflow, wrap or saturate at the
//               maximum count, and a combinational terminal-count carry.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_up_counter
   import bcd_up_counter_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int WRAP   = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        load,
   input  logic                        CE,
   input  logic [DIGIT_W*DIGITS-1:0]   data,
   output logic [DIGIT_W*DIGITS-1:0]   count,
   output logic                        CEO,
   output logic                        error,
   output logic                        overflow
);

   logic              w_data_valid;
   logic              w_all_nines;
   logic              w_ce_ok;
   logic              w_saturate;
   logic              w_digit_load;
   logic              w_ovf_event;
   logic [DIGITS:0]   w_carry;

   // Whole-word checks: every load nibble is BCD, every count digit is 9.
   always_comb begin
      w_data_valid = 1'b1;
      w_all_nines  = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (!is_bcd(data[i*DIGIT_W +: DIGIT_W])) begin
            w_data_valid = 1'b0;
         end
         if (count[i*DIGIT_W +: DIGIT_W] != BCD_MAX) begin
            w_all_nines = 1'b0;
         end
      end
   end

   // An increment is only honoured when no load is pending and no error is held.
   assign w_ce_ok      = CE && !load && !error;
   // In saturating mode the digits are frozen once the maximum is reached.
   assign w_saturate   = (WRAP == 0) && w_all_nines;
   // Invalid loads must leave the digits untouched.
   assign w_digit_load = load && w_data_valid;
   assign w_carry[0]   = w_ce_ok && !w_saturate;

   // Carry out of the top digit means a wrap; in saturating mode the chain is
   // blocked, so the overflow is recognised directly from the maximum state.
   assign w_ovf_event  = w_carry[DIGITS] || (w_ce_ok && w_saturate);

   // Terminal-count carry for cascading, independent of wrap/saturate mode.
   assign CEO = CE && w_all_nines && !error;

   generate
      for (genvar i = 0; i < DIGITS; i++) begin : g_digit
         bcd_up_digit u_digit (
            .clk   (clk),
            .reset (reset),
            .load  (w_digit_load),
            .CE    (w_carry[i]),
            .data  (data[i*DIGIT_W +: DIGIT_W]),
            .count (count[i*DIGIT_W +: DIGIT_W]),
            .CEO   (w_carry[i+1])
         );
      end
   endgenerate

   // Status flags: error follows load validity, overflow is sticky until a valid load.
   always_ff @(posedge clk) begin
      if (reset) begin
         error    <= 1'b0;
         overflow <= 1'b0;
      end else if (load) begin
         if (w_data_valid) begin
            error    <= 1'b0;
            overflow <= 1'b0;
         end else begin
            error    <= 1'b1;
         end
      end else if (w_ovf_event) begin
         overflow <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bcd_up_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_up_counter
// Description : Self-checking bench for bcd_up_counter. One wrapping and one
//               saturating instance share stimulus; a decimal-integer model
//               predicts both, plus directed literal scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_up_counter;

   localparam int MAXV = 9999;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load = 1'b0;
   logic        ce = 1'b0;
   logic [15:0] data = '0;

   logic [15:0] count_w, count_s;
   logic        ceo_w, ceo_s, error_w, error_s, ovf_w, ovf_s;
   logic        ceo_w_smp, ceo_s_smp;

   int total = 0;
   int bad   = 0;

   int  m_val [2];
   bit  m_err [2];
   bit  m_ovf [2];
   bit  started = 1'b0;

   always #5 clk = ~clk;

   bcd_up_counter #(.DIGITS(4), .WRAP(1)) dut_wrap (
      .clk(clk), .reset(reset), .load(load), .CE(ce), .data(data),
      .count(count_w), .CEO(ceo_w), .error(error_w), .overflow(ovf_w)
   );

   bcd_up_counter #(.DIGITS(4), .WRAP(0)) dut_sat (
      .clk(clk), .reset(reset), .load(load), .CE(ce), .data(data),
      .count(count_s), .CEO(ceo_s), .error(error_s), .overflow(ovf_s)
   );

   function automatic int bcd_to_int(input logic [15:0] b);
      int v = 0;
      int w = 1;
      for (int i = 0; i < 4; i++) begin
         v = v + int'(b[i*4 +: 4]) * w;
         w = w * 10;
      end
      return v;
   endfunction

   function automatic logic [15:0] int_to_bcd(input int v);
      logic [15:0] r = '0;
      int t = v;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic bit data_ok(input logic [15:0] b);
      for (int i = 0; i < 4; i++) begin
         if (b[i*4 +: 4] > 4'd9) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Decimal model: count as an integer, flags as plain bits; index 0 wraps, 1 saturates.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            m_val[k] <= 0;
            m_err[k] <= 1'b0;
            m_ovf[k] <= 1'b0;
         end else if (load) begin
            if (data_ok(data)) begin
               m_val[k] <= bcd_to_int(data);
               m_err[k] <= 1'b0;
               m_ovf[k] <= 1'b0;
            end else begin
               m_err[k] <= 1'b1;
            end
         end else if (ce && !m_err[k]) begin
            if (m_val[k] == MAXV) begin
               m_ovf[k] <= 1'b1;
               m_val[k] <= (k == 0) ? 0 : MAXV;
            end else begin
               m_val[k] <= m_val[k] + 1;
            end
         end
      end
      if (reset) started <= 1'b1;
   end

   // Compare both instances against the model on every falling edge.
   always @(negedge clk) begin
      if (started) begin
         check("wrap count", count_w, int_to_bcd(m_val[0]));
         check("wrap error", error_w, m_err[0]);
         check("wrap overflow", ovf_w, m_ovf[0]);
         check("wrap CEO", ceo_w, ce && (m_val[0] == MAXV) && !m_err[0]);
         check("sat count", count_s, int_to_bcd(m_val[1]));
         check("sat error", error_s, m_err[1]);
         check("sat overflow", ovf_s, m_ovf[1]);
         check("sat CEO", ceo_s, ce && (m_val[1] == MAXV) && !m_err[1]);
      end
   end

   task automatic step(input logic r, input logic l, input logic c, input logic [15:0] d);
      reset = r;
      load  = l;
      ce    = c;
      data  = d;
      #1;
      ceo_w_smp = ceo_w;
      ceo_s_smp = ceo_s;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit          any_ceo;
      logic        r, l, c;
      logic [15:0] d;
      logic [15:0] near [4];

      // Reset then 12 increments.
      step(1, 0, 0, 16'h0000);
      check("reset count", count_w, 16'h0000);
      check("reset error", error_w, 1'b0);
      check("reset overflow", ovf_w, 1'b0);
      any_ceo = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step(0, 0, 1, 16'h0000);
         any_ceo = any_ceo | ceo_w_smp;
      end
      check("12 CE count", count_w, 16'h0012);
      check("12 CE no CEO", any_ceo, 1'b0);
      check("12 CE error", error_w, 1'b0);
      check("12 CE overflow", ovf_w, 1'b0);

      // Ripple carry through three digits.
      step(0, 1, 0, 16'h0999);
      step(0, 0, 1, 16'h0000);
      check("0999+1 count", count_w, 16'h1000);
      check("0999+1 CEO", ceo_w_smp, 1'b0);

      // Terminal count: wrap versus saturate.
      step(0, 1, 0, 16'h9999);
      step(0, 0, 1, 16'h0000);
      check("max wrap CEO", ceo_w_smp, 1'b1);
      check("max sat CEO", ceo_s_smp, 1'b1);
      check("max wrap count", count_w, 16'h0000);
      check("max wrap overflow", ovf_w, 1'b1);
      check("max sat count", count_s, 16'h9999);
      check("max sat overflow", ovf_s, 1'b1);
      step(0, 0, 1, 16'h0000);
      check("held sat CEO", ceo_s_smp, 1'b1);
      check("held sat count", count_s, 16'h9999);
      check("after wrap count", count_w, 16'h0001);
      check("after wrap overflow sticky", ovf_w, 1'b1);

      // Invalid load freezes count and sets error.
      step(0, 1, 0, 16'h0042);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 16'h0000);
      step(0, 1, 0, 16'h12A4);
      check("bad load error", error_w, 1'b1);
      check("bad load count", count_w, 16'h0045);
      check("bad load sat count", count_s, 16'h0045);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 16'h0000);
      check("error hold count", count_w, 16'h0045);
      check("error hold flag", error_w, 1'b1);
      step(0, 1, 0, 16'h0005);
      check("recover error", error_w, 1'b0);
      check("recover count", count_w, 16'h0005);

      // Load wins over CE.
      step(0, 1, 1, 16'h0042);
      check("load+CE count", count_w, 16'h0042);

      // Reset wins over load and in-flight counting.
      step(0, 1, 0, 16'h9999);
      step(0, 0, 1, 16'h0000);
      step(0, 0, 1, 16'h0000);
      step(1, 1, 1, 16'h0777);
      check("reset+load count", count_w, 16'h0000);
      check("reset+load error", error_w, 1'b0);
      check("reset+load overflow", ovf_w, 1'b0);
      check("reset+load sat overflow", ovf_s, 1'b0);
      step(0, 0, 1, 16'h0000);
      check("first CE after reset", count_w, 16'h0001);

      // Randomised traffic checked by the model each cycle.
      near[0] = 16'h9999;
      near[1] = 16'h9998;
      near[2] = 16'h0999;
      near[3] = 16'h9989;
      for (int n = 0; n < 800; n++) begin
         r = ($urandom_range(0, 49) == 0);
         l = ($urandom_range(0, 7) == 0);
         c = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 7))
            6: begin
               d = 16'($urandom);
               d[$urandom_range(0, 3)*4 +: 4] = 4'($urandom_range(10, 15));
            end
            7: d = near[$urandom_range(0, 3)];
            default: begin
               for (int i = 0; i < 4; i++) d[i*4 +: 4] = 4'($urandom_range(0, 9));
            end
         endcase
         step(r, l, c, d);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bcd_up_counter.md
BCD_UP_COUNTER -- requirements
Module: bcd_up_counter

Interface
REQ-001 Parameters SHALL be: DIGITS, default 4, number of cascaded BCD digits; WRAP, default 1, where 1 means roll over past the maximum count and 0 means saturate at it.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 load  input  1  parallel-load strobe.
REQ-005 CE  input  1  count enable; one increment per cycle while high.
REQ-006 data  input  4*DIGITS  BCD load value, with digit 0 in bits [3:0].
REQ-007 count  output  4*DIGITS  registered BCD count value.
REQ-008 CEO  output  1  combinational terminal-count carry for cascading further counters.
REQ-009 error  output  1  registered flag, set on an invalid BCD load.
REQ-010 overflow  output  1  registered sticky flag, set when the count passes its maximum.

Function
REQ-011 Priority SHALL be, highest first: reset, load, CE; when load and CE are high in the same cycle, only the load SHALL take effect.
REQ-012 On load, if any data nibble is greater than 9, the block SHALL set error=1 and hold count and overflow unchanged.
REQ-013 On load with all nibbles at 9 or below, the block SHALL set count=data, error=0 and overflow=0 on the next edge.
REQ-014 While error=1, CE SHALL have no effect; error SHALL stay set until a valid load or a reset.
REQ-015 With CE=1, load=0 and error=0, digit i SHALL increment when every lower digit equals 9.
REQ-016 A digit at 9 that increments SHALL become 0; no digit SHALL ever hold a value from A to F.
REQ-017 CEO SHALL equal CE AND (every digit = 9) AND NOT error, asserting in the same cycle as the terminal-count state.
REQ-018 With WRAP=1, CE at the maximum count (all digits 9) SHALL give count=0 and overflow=1.
REQ-019 With WRAP=0, CE at the maximum count SHALL hold count at the maximum and set overflow=1.
REQ-020 With WRAP=0, CEO SHALL still assert at the maximum count while CE=1.
REQ-021 overflow SHALL stay set until a valid load or a reset.
REQ-022 Latency SHALL be exactly one clock from load or CE to the updated count; there is no pipelining.

Reset
REQ-023 Reset SHALL force count=0, error=0 and overflow=0 on the next rising edge, regardless of load, CE or data.
REQ-024 Reset asserted in the middle of counting SHALL discard the in-flight increment.
REQ-025 After reset the block SHALL count from 0 on the first edge where CE=1 and reset=0.

Structure
REQ-026 A shared package SHALL hold the constants BCD_MAX=9 and DIGIT_W=4, plus the function that tests whether a nibble is valid BCD.
REQ-027 The block SHALL instantiate DIGITS copies of the sub-module bcd_up_digit, chained through a generate loop.
REQ-028 The bcd_up_digit ports SHALL be clk, reset, load, CE, data[3:0], count[3:0] and CEO, where CEO = CE AND (count = 9).
REQ-029 The CE input of digit i SHALL be the CEO output of digit i-1.
REQ-030 Validation of the whole load value, error, overflow and WRAP saturation SHALL live in the top level.
REQ-031 The top level SHALL suppress the digit CE inputs when saturating or when error=1.

Verification
REQ-032 Reset, then CE held for 12 cycles -> count=0x0012, CEO=0 throughout, error=0, overflow=0.
REQ-033 Load 0x0999, then one CE cycle -> count=0x1000, and the digit 0-2 carries assert during the CE cycle.
REQ-034 Load 0x9999, then one CE cycle -> CEO=1 in that cycle; with WRAP=1, count=0x0000 and overflow=1; with WRAP=0, count=0x9999 and overflow=1.
REQ-035 Load 0x0042, CE for 3 cycles, then load 0x12A4 -> error=1 and count=0x0045.
REQ-036 Continuing REQ-035: 5 further CE cycles -> count=0x0045 unchanged; then load 0x0005 -> error=0 and count=0x0005.
REQ-037 Load and CE high in the same cycle with data=0x0042 -> count=0x0042 after one edge.
REQ-038 Reset high together with load of data=0x0777 during counting -> count=0x0000, error=0, overflow=0.
